// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared defaults and types for the instruction prefetch queue.
//               FQ_DEPTH/FQ_AW/FQ_DW are the default queue depth, PC width and
//               instruction width; fetch_entry_t is one queue entry {pc, instr}.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_AW    = 8;
  localparam int FQ_DW    = 8;
  localparam int FQ_PTR_W = $clog2(FQ_DEPTH);

  typedef struct packed {
    logic [FQ_AW-1:0] pc;
    logic [FQ_DW-1:0] instr;
  } fetch_entry_t;

  // Pointer width for a ring of the given depth (depth is a power of two).
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Ring-buffer FIFO holding prefetched {pc, instr} entries.
//               Power-of-two depth, so pointers wrap naturally.
// Ports       : clock, reset (async, active-high)
//               clear      - empties the FIFO; dominates push and pop
//               push/push_data - write an entry at the tail
//               pop        - advance the head (caller guarantees !empty)
//               head_data  - entry at the head
//               count/full/empty - fill status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int W     = FQ_AW + FQ_DW
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          push,
  input  logic [W-1:0]                  push_data,
  input  logic                          pop,
  output logic [W-1:0]                  head_data,
  output logic [ptr_width(DEPTH):0]     count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while count != 0.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[tail] <= push_data;
  end

  assign head_data = mem[head];
  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction prefetch stage. Owns the fetch PC, issues
//               sequential instruction-port reads, buffers returned words with
//               their PCs and hands them downstream over valid/ready. A flush
//               empties the queue, drops the in-flight read and restarts at
//               flush_pc.
//               Optional: FETCH_QUEUE_BYPASS_EN forwards a return straight to
//               deq_* when the queue is empty (1-cycle fill latency).
// Ports       : clock, reset (async, active-high)
//               flush, flush_pc           - redirect request / target
//               imem_rd, imem_addr        - read request, address = fetch PC
//               imem_data                 - read data, cycle after imem_rd
//               deq_valid/instr/pc/ready  - downstream handshake
//               occupancy                 - entries held in the queue
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = FQ_AW,
  parameter int DW    = FQ_DW
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [AW-1:0]              flush_pc,
  output logic                       imem_rd,
  output logic [AW-1:0]              imem_addr,
  input  logic [DW-1:0]              imem_data,
  output logic                       deq_valid,
  output logic [DW-1:0]              deq_instr,
  output logic [AW-1:0]              deq_pc,
  input  logic                       deq_ready,
  output logic [ptr_width(DEPTH):0]  occupancy
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [AW-1:0]    fetch_pc;
  logic             inflight;
  logic [AW-1:0]    inflight_pc;

  logic [PTR_W:0]   fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW+DW-1:0] fifo_head;
  logic             fifo_push;
  logic             fifo_pop;

  logic [PTR_W+1:0] reserved;
  logic             ret_valid;
  logic [AW+DW-1:0] ret_entry;
  logic [AW+DW-1:0] out_entry;

  // Slots already committed: stored entries plus the read on its way back.
  // Same-cycle pops give no credit, so a return can never overflow the FIFO.
  assign reserved  = {1'b0, fifo_count} + (PTR_W+2)'(inflight);
  assign imem_rd   = !reset && !flush && !fifo_full && (reserved < (PTR_W+2)'(DEPTH));
  assign imem_addr = fetch_pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (flush) begin
      fetch_pc    <= flush_pc;
      inflight    <= 1'b0;
    end else begin
      inflight <= imem_rd;
      if (imem_rd) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end
    end
  end

  // A return arriving in a flush cycle belongs to the old stream: drop it.
  assign ret_valid = inflight && !flush;
  assign ret_entry = {inflight_pc, imem_data};

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass    = ret_valid && fifo_empty;
  assign fifo_push = ret_valid && !(bypass && deq_ready);
  assign deq_valid = !fifo_empty || bypass;
  assign out_entry = fifo_empty ? ret_entry : fifo_head;
`else
  assign fifo_push = ret_valid;
  assign deq_valid = !fifo_empty;
  assign out_entry = fifo_head;
`endif

  // Only stored entries pop; a bypassed entry that is accepted is never stored.
  assign fifo_pop  = !fifo_empty && deq_ready;

  assign deq_pc    = deq_valid ? out_entry[AW+DW-1:DW] : '0;
  assign deq_instr = deq_valid ? out_entry[DW-1:0]     : '0;
  assign occupancy = fifo_count;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (fifo_push),
    .push_data (ret_entry),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue (DEPTH=4, AW=DW=8).
//               Memory returns instr = addr + 0x10. A queue-of-PCs model
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic [7:0] flush_pc;
  logic       imem_rd;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       deq_valid;
  logic [7:0] deq_instr;
  logic [7:0] deq_pc;
  logic       deq_ready;
  logic [2:0] occupancy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fetch_queue #(.DEPTH(4), .AW(8), .DW(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .imem_rd   (imem_rd),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .deq_valid (deq_valid),
    .deq_instr (deq_instr),
    .deq_pc    (deq_pc),
    .deq_ready (deq_ready),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  // Instruction memory: word at address a is a + 0x10, one cycle latency.
  always @(posedge clock) begin
    if (imem_rd) imem_data <= imem_addr + 8'h10;
  end

  // Reference model: stored PCs in order, one pending read, the fetch PC.
  logic [7:0] m_q[$];
  logic [7:0] m_fpc;
  bit         m_pend;
  logic [7:0] m_pend_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fpc     = 8'h00;
    m_pend    = 0;
    m_pend_pc = 8'h00;
  endtask

  function automatic bit exp_rd();
    return !reset && !flush && (m_q.size() + int'(m_pend) < 4);
  endfunction

  // Head presented downstream: stored head, or (bypass) the returning word.
  function automatic bit exp_valid(output logic [7:0] pc);
    pc = 8'h00;
    if (m_q.size() != 0) begin
      pc = m_q[0];
      return 1;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (m_pend && !flush && !reset) begin
      pc = m_pend_pc;
      return 1;
    end
`endif
    return 0;
  endfunction

  task automatic compare_outputs();
    logic [7:0] pc;
    logic [7:0] ins;
    bit         v;
    v   = exp_valid(pc);
    ins = v ? pc + 8'h10 : 8'h00;
    chk("imem_rd",   {31'd0, imem_rd},   {31'd0, exp_rd()});
    chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_fpc});
    chk("deq_valid", {31'd0, deq_valid}, {31'd0, v});
    chk("deq_pc",    {24'd0, deq_pc},    {24'd0, pc});
    chk("deq_instr", {24'd0, deq_instr}, {24'd0, ins});
    chk("occupancy", {29'd0, occupancy}, m_q.size());
  endtask

  task automatic model_step();
    logic [7:0] pc;
    bit v, rd, from_store;
    if (reset) begin
      model_reset();
      return;
    end
    rd         = exp_rd();
    v          = exp_valid(pc);
    from_store = (m_q.size() != 0);
    if (v && deq_ready && from_store) void'(m_q.pop_front());
    if (flush) begin
      m_q.delete();
      m_pend = 0;
      m_fpc  = flush_pc;
    end else begin
      // A returning word is stored unless it was handed straight out.
      if (m_pend && !(v && !from_store && deq_ready)) m_q.push_back(m_pend_pc);
      m_pend = rd;
      if (rd) begin
        m_pend_pc = m_fpc;
        m_fpc     = m_fpc + 8'h01;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    compare_outputs();
    @(posedge clock);
    model_step();
    cyc++;
    #1;
  endtask

  initial begin
    int guard;
    reset     = 1'b1;
    flush     = 1'b0;
    flush_pc  = 8'h00;
    deq_ready = 1'b1;
    imem_data = 8'h00;
    model_reset();
    repeat (2) cycle();
    reset = 1'b0;

    // Free-running stream.
    repeat (20) cycle();

    // Back-pressure: queue fills, reads stop, then drains in order.
    deq_ready = 1'b0;
    repeat (10) cycle();
    chk("occ_full", {29'd0, occupancy}, 32'd4);
    deq_ready = 1'b1;
    repeat (10) cycle();

    // Flush while 3 entries are queued and a read is in flight.
    deq_ready = 1'b0;
    guard = 0;
    while (!(m_q.size() == 3 && m_pend) && guard < 20) begin
      cycle();
      guard++;
    end
    chk("flush_setup", guard < 20, 32'd1);
    flush    = 1'b1;
    flush_pc = 8'h40;
    cycle();
    flush     = 1'b0;
    deq_ready = 1'b1;
    repeat (8) cycle();

    // PC wrap 0xFF -> 0x00.
    flush    = 1'b1;
    flush_pc = 8'hFE;
    cycle();
    flush = 1'b0;
    repeat (10) cycle();

    // Back-to-back flushes: the last target wins.
    flush    = 1'b1;
    flush_pc = 8'h80;
    cycle();
    flush_pc = 8'h90;
    cycle();
    flush = 1'b0;
    repeat (6) cycle();

    // Random traffic with occasional redirects.
    for (int i = 0; i < 300; i++) begin
      deq_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      flush_pc  = 8'($urandom);
      cycle();
    end
    flush     = 1'b0;
    deq_ready = 1'b1;
    repeat (6) cycle();

    // Asynchronous reset pulse between clock edges.
    #2;
    reset = 1'b1;
    #1;
    chk("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
    chk("rst_deq_pc",    {24'd0, deq_pc},    32'd0);
    chk("rst_deq_instr", {24'd0, deq_instr}, 32'd0);
    chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
    chk("rst_imem_rd",   {31'd0, imem_rd},   32'd0);
    model_reset();
    repeat (2) cycle();
    reset = 1'b0;
    repeat (15) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_queue
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch stage sitting directly upstream of the fetch instruction register (IR1). Owns the fetch PC, issues sequential reads to the instruction port of the dual-port memory, buffers returned instructions with their PCs in a small FIFO, and presents them to the fetch/decode controllers through a valid/ready handshake. A branch redirect flushes the queue, drops any in-flight read, and restarts fetching at the target.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- AW, 8, PC/address width
- DW, 8, instruction width
- clock  in  1  rising-edge clock for all state
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  redirect request; highest priority
- flush_pc  in  AW  redirect target, sampled when flush=1
- imem_rd  out  1  instruction read request this cycle
- imem_addr  out  AW  read address (= fetch PC)
- imem_data  in  DW  read data, valid the cycle after imem_rd
- deq_valid  out  1  head entry available
- deq_instr  out  DW  head instruction; 0 when deq_valid=0
- deq_pc  out  AW  PC of head instruction; 0 when deq_valid=0
- deq_ready  in  1  consumer accepts head this cycle
- occupancy  out  log2(DEPTH)+1  entries currently stored

## Operation
- State: fetch_pc (AW), FIFO (DEPTH × {pc, instr}), count, inflight flag, inflight_pc.
- Reset values: fetch_pc=0, count=0, inflight=0; imem_rd=0 while reset high; deq_valid=0, deq_instr=0, deq_pc=0, occupancy=0.
- Issue: imem_rd = !flush && (count + inflight < DEPTH); imem_addr = fetch_pc combinationally. On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^AW; 0xFF wraps to 0x00).
- No issue cycle: inflight<=0.
- Return: when inflight=1 and no flush, {inflight_pc, imem_data} is pushed at end of cycle.
- Dequeue: when deq_valid && deq_ready, head pops at end of cycle.
- Simultaneous push and pop: both occur; count unchanged. Issue gating uses registered count+inflight (no credit from same-cycle pop), so push never overflows.
- Pop with deq_valid=0: ignored.
- Flush: at end of cycle, count<=0, inflight<=0 (returning data that cycle or next discarded), fetch_pc<=flush_pc; imem_rd=0 in flush cycle; pop in flush cycle is still honoured (consumer saw it) but the queue is then empty.
- Flush on consecutive cycles: last flush_pc wins.
- Reset asserted mid-operation: all state cleared immediately; in-flight read discarded.

## Timing
- Cycle 0 after reset release: imem_rd=1, imem_addr=0.
- Cycle 1: imem_data holds instr@0; pushed at end of cycle 1.
- Cycle 2: deq_valid=1, deq_pc=0 (fill-to-output latency 2 cycles).
- Steady state with deq_ready=1: one instruction per cycle.
- Flush in cycle t: first fetch of flush_pc in t+1, deq_valid in t+3.
- deq_ready low: queue fills to DEPTH, imem_rd deasserts, no entry lost or duplicated.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count=0 and a valid return arrives, the returned entry is driven on deq_* in the same cycle (deq_valid=1 at t+1); if deq_ready=1 it is not written to the FIFO, otherwise it is pushed. Fill latency becomes 1 cycle; after flush, deq_valid in t+2.
- Undefined: all returns pass through FIFO storage; latencies as in Timing.

## Structure
- Package fetch_pkg: AW/DW/DEPTH defaults, entry struct {pc, instr}, pointer-width constant clog2(DEPTH).
- Sub-module fetch_fifo: ring buffer with head/tail pointers and count, push/pop/clear inputs, full/empty outputs; fetch_queue holds PC, inflight tracking, flush and bypass logic.

## Test plan
- Reset release, deq_ready=1, mem[i]=i+0x10 -> deq sequence pc 0,1,2… with instr 0x10,0x11…, first deq_valid cycle 2, one per cycle thereafter.
- deq_ready=0 for 10 cycles -> occupancy reaches DEPTH=4, imem_rd low; release -> pcs 0..3 then 4 with no gaps or repeats.
- flush with flush_pc=0x40 while 3 entries queued and read in flight -> occupancy 0 next cycle, next deq_pc=0x40 at t+3, no stale pc delivered.
- fetch_pc=0xFE free-running -> deq_pc sequence 0xFE,0xFF,0x00,0x01.
- Async reset pulse mid-stream (between clock edges) -> outputs 0 immediately, restart from pc 0 after release.
- FETCH_QUEUE_BYPASS_EN defined, empty queue, deq_ready=1 -> deq_valid at t+1 after issue, occupancy stays 0.
